// File: rtl/i_fetch_pkg.sv
// Shared definitions for the MIPS instruction-fetch stage: datapath width,
// the NOP encoding and the fixed boot program held in the instruction ROM.
package i_fetch_pkg;

    localparam int DATA_W  = 32;
    localparam int ROM_LEN = 10;

    localparam logic [DATA_W-1:0] NOP = 32'h0000_0000;

    // Program image for words 0..ROM_LEN-1; every other word reads as NOP.
    localparam logic [DATA_W-1:0] ROM_INIT [ROM_LEN] = '{
        32'hA000_00AA,
        32'h1000_0011,
        32'h2000_0022,
        32'h3000_0033,
        32'h4000_0044,
        32'h5000_0055,
        32'h6000_0066,
        32'h7000_0077,
        32'h8000_0088,
        32'h9000_0099
    };

endpackage

// File: rtl/i_fetch_imem.sv
// Read-only instruction memory with a combinational read port.
// MEM_DEPTH words, indexed by an ADDR_W-bit word address.
module i_fetch_imem
    import i_fetch_pkg::*;
#(
    parameter int MEM_DEPTH = 128,
    parameter int ADDR_W    = 7
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] w_rom [MEM_DEPTH];

    // Constant contents built at elaboration time.
    // NOTE: the ROM is pure wiring to constants, so it has no storage and
    // nothing to reset; a reset on a memory array would only cost logic.
    for (genvar g = 0; g < MEM_DEPTH; g++) begin : g_rom
        if (g < ROM_LEN) begin : g_prog
            assign w_rom[g] = ROM_INIT[g];
        end else begin : g_fill
            assign w_rom[g] = NOP;
        end
    end

    assign o_data = w_rom[i_addr];

endmodule

// File: rtl/i_fetch.sv
// MIPS IF stage: PC register, next-PC select (PC+1 or EX/MEM branch target),
// instruction ROM read and the IF/ID pipeline latch.
// Optional build macro: I_FETCH_STALL_EN adds a 'stall' input that freezes
// the PC and the IF/ID latch (reset still wins over stall).
module i_fetch
    import i_fetch_pkg::*;
#(
    parameter int MEM_DEPTH = 128,
    parameter int ADDR_W    = 7
) (
    input  logic              clk,
    input  logic              rst,
`ifdef I_FETCH_STALL_EN
    input  logic              stall,
`endif
    input  logic              PCSrc,
    input  logic [DATA_W-1:0] EX_MEM_NPC,
    output logic [DATA_W-1:0] IF_ID_IR,
    output logic [DATA_W-1:0] IF_ID_NPC
);

    // NOTE: the declaration initialiser only gives simulation a known PC
    // before the first reset; the real reset is the synchronous rst below.
    logic [DATA_W-1:0] r_pc = '0;
    logic [DATA_W-1:0] r_if_id_ir;
    logic [DATA_W-1:0] r_if_id_npc;

    logic [DATA_W-1:0] w_npc;
    logic [DATA_W-1:0] w_next_pc;
    logic [DATA_W-1:0] w_instr;
    logic              w_stall;

`ifdef I_FETCH_STALL_EN
    assign w_stall = stall;
`else
    assign w_stall = 1'b0;
`endif

    // Word-addressed PC: sequential successor is PC+1, wrapping at 2^32.
    assign w_npc     = r_pc + DATA_W'(1);
    assign w_next_pc = PCSrc ? EX_MEM_NPC : w_npc;

    // Upper PC bits are dropped here, so fetch addresses wrap in the ROM.
    i_fetch_imem #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_imem (
        .i_addr (r_pc[ADDR_W-1:0]),
        .o_data (w_instr)
    );

    // Advance the PC and load the IF/ID latch every cycle unless held.
    // NOTE: non-blocking assignments so every register samples the values
    // from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= '0;
            r_if_id_ir  <= NOP;
            r_if_id_npc <= '0;
        end else if (!w_stall) begin
            r_pc        <= w_next_pc;
            r_if_id_ir  <= w_instr;
            r_if_id_npc <= w_npc;
        end
    end

    assign IF_ID_IR  = r_if_id_ir;
    assign IF_ID_NPC = r_if_id_npc;

endmodule

// File: tb/tb_i_fetch.sv
// Scoreboard bench for i_fetch: the driver applies directed and random
// stimulus and queues the expected IF/ID contents from a simple program-
// counter model; the monitor pops and compares once per cycle.
module tb_i_fetch;

`ifdef I_FETCH_STALL_EN
    localparam bit HAS_STALL = 1'b1;
`else
    localparam bit HAS_STALL = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] npc;
    } resp_t;

    bit          clk = 1'b0;
    logic        rst;
    logic        PCSrc;
    logic [31:0] EX_MEM_NPC;
    logic [31:0] IF_ID_IR;
    logic [31:0] IF_ID_NPC;
`ifdef I_FETCH_STALL_EN
    logic        stall;
`endif

    int unsigned n_vectors    = 0;
    int unsigned n_miscompare = 0;

    resp_t       exp_q[$];

    // Reference state: architectural PC and current IF/ID contents.
    logic [31:0] m_pc  = 32'd0;
    resp_t       m_out = '0;

    always #5 clk = ~clk;

    i_fetch dut (
        .clk        (clk),
        .rst        (rst),
`ifdef I_FETCH_STALL_EN
        .stall      (stall),
`endif
        .PCSrc      (PCSrc),
        .EX_MEM_NPC (EX_MEM_NPC),
        .IF_ID_IR   (IF_ID_IR),
        .IF_ID_NPC  (IF_ID_NPC)
    );

    // Program listing; the ROM repeats every 128 words.
    function automatic logic [31:0] ref_rom(input logic [31:0] pc);
        case (pc % 32'd128)
            32'd0:   return 32'hA00000AA;
            32'd1:   return 32'h10000011;
            32'd2:   return 32'h20000022;
            32'd3:   return 32'h30000033;
            32'd4:   return 32'h40000044;
            32'd5:   return 32'h50000055;
            32'd6:   return 32'h60000066;
            32'd7:   return 32'h70000077;
            32'd8:   return 32'h80000088;
            32'd9:   return 32'h90000099;
            default: return 32'h00000000;
        endcase
    endfunction

    task automatic check(input string name, input resp_t act, input resp_t exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got IR=%h NPC=%0d, expected IR=%h NPC=%0d",
                     name, act.ir, act.npc, exp.ir, exp.npc);
        end
    endtask

    // One clock of stimulus: drive inputs, predict the latch after the edge.
    task automatic step(input logic r, input logic src, input logic [31:0] tgt,
                        input logic stl);
        rst        = r;
        PCSrc      = src;
        EX_MEM_NPC = tgt;
`ifdef I_FETCH_STALL_EN
        stall      = stl;
`endif
        if (r) begin
            m_pc  = 32'd0;
            m_out = '0;
        end else if (!(stl && HAS_STALL)) begin
            m_out.ir  = ref_rom(m_pc);
            m_out.npc = m_pc + 32'd1;
            m_pc      = src ? tgt : m_pc + 32'd1;
        end
        exp_q.push_back(m_out);
        @(posedge clk);
        #1;
    endtask

    task automatic seq(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    // Monitor: outputs are stable at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                resp_t e;
                e = exp_q.pop_front();
                check("if_id", '{ir: IF_ID_IR, npc: IF_ID_NPC}, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver.
    initial begin
        logic [31:0] tgt;
        logic        r, src, stl;

        // First edge without reset: PC starts at 0.
        step(1'b0, 1'b0, 32'd0, 1'b0);

        // Reset, then run through the program and past its end.
        step(1'b1, 1'b0, 32'd0, 1'b0);
        seq(12);

        // Branch redirect to 7 after three sequential fetches.
        step(1'b1, 1'b0, 32'd0, 1'b0);
        seq(3);
        step(1'b0, 1'b1, 32'd7, 1'b0);
        seq(3);

        // Target beyond the ROM depth wraps the index but not NPC.
        step(1'b0, 1'b1, 32'd130, 1'b0);
        seq(2);

        // Branch to PC+1 is indistinguishable from sequential fetch.
        step(1'b0, 1'b1, m_pc + 32'd1, 1'b0);
        seq(1);

        // PC wrap from all-ones to zero.
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        seq(3);

        // Mid-stream reset at PC=5 overrides a pending branch.
        step(1'b1, 1'b0, 32'd0, 1'b0);
        seq(5);
        step(1'b1, 1'b1, 32'd9, 1'b0);
        seq(2);

        // Stall for three edges with NPC=4 in the latch, branch ignored.
        step(1'b1, 1'b0, 32'd0, 1'b0);
        seq(4);
        step(1'b0, 1'b1, 32'd2, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b1, 32'd8, 1'b1);
        seq(2);
        // Reset wins over stall.
        step(1'b1, 1'b0, 32'd0, 1'b1);
        seq(1);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 39) == 0);
            src = ($urandom_range(0, 3) == 0);
            stl = ($urandom_range(0, 6) == 0);
            case ($urandom_range(0, 3))
                0:       tgt = $urandom_range(0, 12);
                1:       tgt = $urandom_range(120, 300);
                2:       tgt = $urandom;
                default: tgt = 32'hFFFF_FFFF - $urandom_range(0, 2);
            endcase
            step(r, src, tgt, stl);
        end

        step(1'b0, 1'b0, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_vectors++;
            n_miscompare++;
            $display("FAIL drain: %0d responses left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompare);
        $finish;
    end

endmodule
